// File: rtl/ds18b20_pkg.sv
// Shared constants, state encoding and CRC step function for the DS18B20 read sequencer.
package ds18b20_pkg;

  localparam logic [7:0] SKIP_ROM     = 8'hCC;
  localparam logic [7:0] CONVERT_T    = 8'h44;
  localparam logic [7:0] READ_SCRATCH = 8'hBE;
  localparam logic [7:0] CRC_POLY     = 8'h8C;

  typedef enum logic [3:0] {
    IDLE, RST1, CMD1, CONV, GAP, RST2, CMD2, RD8, RDC, CRC
  } state_t;

  typedef enum logic [1:0] {
    PH_ISSUE, PH_WAIT_BUSY, PH_WAIT_IDLE
  } phase_t;

  // One bit of the reflected Dallas CRC-8: shift right, fold polynomial on feedback.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[0] ^ din;
    return fb ? ((crc >> 1) ^ CRC_POLY) : (crc >> 1);
  endfunction

endpackage

// File: rtl/ds_crc8.sv
// Bit-serial Dallas CRC-8 accumulator; clr has priority over en.
module ds_crc8
  import ds18b20_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (reset || clr)
      crc <= 8'h00;
    else if (en)
      crc <= crc8_step(crc, din);
  end

endmodule

// File: rtl/ds18b20_ctrl.sv
// DS18B20 temperature-read sequencer driving the 1-Wire bit engine.
module ds18b20_ctrl
  import ds18b20_pkg::*;
#(
  parameter int CONV_TIMEOUT = 18000000,
  parameter int POLL_GAP     = 24000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        ready,
  output logic [15:0] temp,
  output logic        temp_valid,
  output logic        err_nodev,
  output logic        err_crc,
  output logic        err_timeout,
  output logic        ow_reset,
  output logic        ow_write,
  output logic        ow_read,
  output logic [63:0] ow_in_byte,
  output logic [5:0]  ow_start_bit,
  output logic [5:0]  ow_end_bit,
  input  logic        ow_busy,
  input  logic        ow_presence,
  input  logic [63:0] ow_out_byte
);

  localparam logic [24:0] CONV_LIMIT = 25'(CONV_TIMEOUT);
  localparam logic [14:0] GAP_LAST   = 15'(POLL_GAP - 1);

  state_t      state;
  phase_t      phase;
  logic [24:0] conv_timer;
  logic [14:0] gap_cnt;
  logic [6:0]  bit_cnt;
  logic [63:0] sp;
  logic [7:0]  crc_rx;
  logic [7:0]  crc;

  assign ready = (state == IDLE) && !ow_busy;

  // The CRC unit is held clear outside CRC, so it starts from zero on entry.
  ds_crc8 u_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (state != CRC),
    .en    ((state == CRC) && !bit_cnt[6]),
    .din   (sp[bit_cnt[5:0]]),
    .crc   (crc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      phase        <= PH_ISSUE;
      conv_timer   <= '0;
      gap_cnt      <= '0;
      bit_cnt      <= '0;
      sp           <= '0;
      crc_rx       <= '0;
      temp         <= '0;
      temp_valid   <= 1'b0;
      err_nodev    <= 1'b0;
      err_crc      <= 1'b0;
      err_timeout  <= 1'b0;
      ow_reset     <= 1'b0;
      ow_write     <= 1'b0;
      ow_read      <= 1'b0;
      ow_in_byte   <= '0;
      ow_start_bit <= '0;
      ow_end_bit   <= '0;
    end else begin
      ow_reset    <= 1'b0;
      ow_write    <= 1'b0;
      ow_read     <= 1'b0;
      temp_valid  <= 1'b0;
      err_nodev   <= 1'b0;
      err_crc     <= 1'b0;
      err_timeout <= 1'b0;

      if ((state == CONV || state == GAP) && conv_timer != '1)
        conv_timer <= conv_timer + 25'd1;

      case (state)
        IDLE: begin
          if (start && !ow_busy) begin
            state <= RST1;
            phase <= PH_ISSUE;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= CONV;
            phase <= PH_ISSUE;
          end else begin
            gap_cnt <= gap_cnt + 15'd1;
          end
        end

        CRC: begin
          if (bit_cnt[6]) begin
            if (crc == crc_rx) begin
              temp       <= sp[15:0];
              temp_valid <= 1'b1;
            end else begin
              err_crc <= 1'b1;
            end
            state <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + 7'd1;
          end
        end

        default: begin
          case (phase)
            PH_ISSUE: begin
              if (!ow_busy) begin
                phase        <= PH_WAIT_BUSY;
                ow_in_byte   <= '0;
                ow_start_bit <= 6'd0;
                ow_end_bit   <= 6'd0;
                case (state)
                  RST1, RST2: ow_reset <= 1'b1;
                  CMD1: begin
                    ow_write   <= 1'b1;
                    ow_in_byte <= {48'd0, CONVERT_T, SKIP_ROM};
                    ow_end_bit <= 6'd15;
                  end
                  CMD2: begin
                    ow_write   <= 1'b1;
                    ow_in_byte <= {48'd0, READ_SCRATCH, SKIP_ROM};
                    ow_end_bit <= 6'd15;
                  end
                  CONV: ow_read <= 1'b1;
                  RD8: begin
                    ow_read    <= 1'b1;
                    ow_end_bit <= 6'd63;
                  end
                  RDC: begin
                    ow_read    <= 1'b1;
                    ow_end_bit <= 6'd7;
                  end
                  default: phase <= PH_ISSUE;
                endcase
              end
            end

            PH_WAIT_BUSY: begin
              if (ow_busy)
                phase <= PH_WAIT_IDLE;
            end

            default: begin
              if (!ow_busy) begin
                phase <= PH_ISSUE;
                case (state)
                  RST1, RST2: begin
                    if (!ow_presence) begin
                      err_nodev <= 1'b1;
                      state     <= IDLE;
                    end else begin
                      state <= (state == RST1) ? CMD1 : CMD2;
                    end
                  end
                  CMD1: begin
                    state      <= CONV;
                    conv_timer <= '0;
                  end
                  // Done bit wins over a simultaneous timeout.
                  CONV: begin
                    if (ow_out_byte[0]) begin
                      state <= RST2;
                    end else if (conv_timer >= CONV_LIMIT) begin
                      err_timeout <= 1'b1;
                      state       <= IDLE;
                    end else begin
                      state   <= GAP;
                      gap_cnt <= '0;
                    end
                  end
                  CMD2: state <= RD8;
                  RD8: begin
                    sp    <= ow_out_byte;
                    state <= RDC;
                  end
                  RDC: begin
                    crc_rx  <= ow_out_byte[7:0];
                    bit_cnt <= '0;
                    state   <= CRC;
                  end
                  default: state <= IDLE;
                endcase
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ds18b20_ctrl.sv
// Self-checking bench: behavioural 1-Wire engine + DS18B20 device model and result scoreboard.
module tb_ds18b20_ctrl;

  localparam int K_VALID = 0, K_CRC = 1, K_NODEV = 2, K_TMO = 3;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        ready, temp_valid, err_nodev, err_crc, err_timeout;
  logic [15:0] temp;
  logic        ow_reset, ow_write, ow_read, ow_busy, ow_presence;
  logic [63:0] ow_in_byte, ow_out_byte;
  logic [5:0]  ow_start_bit, ow_end_bit;

  int total = 0, bad = 0;

  // Device model configuration
  bit         dev_present = 1'b1;
  int         dev_done_poll = 4;
  logic [7:0] dev_sp [9];
  logic [15:0] exp_temp = 16'h0000;

  // Engine-side observations
  int n_reset, n_write, n_poll, n_rd8, n_rdc, n_cmd;
  int n_valid, n_nodev, n_crc, n_tmo;
  logic [15:0] w_data [2];
  logic [5:0]  w_eb [2];
  bit rd8_active = 0, cmd2_busy = 0, hold_busy = 0, long_cmd2 = 0, skip_hold = 0;

  ds18b20_ctrl #(.CONV_TIMEOUT(2000), .POLL_GAP(100)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .temp(temp),
    .temp_valid(temp_valid), .err_nodev(err_nodev), .err_crc(err_crc),
    .err_timeout(err_timeout), .ow_reset(ow_reset), .ow_write(ow_write),
    .ow_read(ow_read), .ow_in_byte(ow_in_byte), .ow_start_bit(ow_start_bit),
    .ow_end_bit(ow_end_bit), .ow_busy(ow_busy), .ow_presence(ow_presence),
    .ow_out_byte(ow_out_byte)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Reference CRC: Dallas/Maxim CRC-8 over scratchpad bytes 0..7, LSB first.
  function automatic logic [7:0] crc_model();
    logic [7:0] c = 8'h00;
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b = dev_sp[i];
      for (int k = 0; k < 8; k++) begin
        if ((c[0] ^ b[0]) == 1'b1) c = (c >> 1) ^ 8'h8C;
        else c = c >> 1;
        b = b >> 1;
      end
    end
    return c;
  endfunction

  // Result pulse monitor
  initial forever begin
    @(posedge clk); #1;
    if (temp_valid)  n_valid++;
    if (err_nodev)   n_nodev++;
    if (err_crc)     n_crc++;
    if (err_timeout) n_tmo++;
  end

  // Behavioural 1-Wire engine with DS18B20 responses
  initial begin
    logic [2:0]  cmd;
    logic [63:0] ib;
    logic [5:0]  sb, eb;
    int len;
    ow_busy = 0; ow_presence = 0; ow_out_byte = '0;
    forever begin
      @(posedge clk); #1;
      cmd = {ow_reset, ow_write, ow_read};
      if (cmd == 3'b000) begin
        ow_busy = hold_busy;
      end else begin
        n_cmd++;
        total++;
        if (ow_busy || !$onehot(cmd)) begin
          bad++;
          $display("FAIL cmd_issue: cmd=%b busy=%0b required onehot with busy=0", cmd, ow_busy);
        end
        ib = ow_in_byte; sb = ow_start_bit; eb = ow_end_bit;
        if (ow_write) begin
          if (n_write < 2) begin w_data[n_write] = ib[15:0]; w_eb[n_write] = eb; end
          n_write++;
          if (ib[15:0] == 16'hBECC) cmd2_busy = 1;
        end
        if (ow_reset) n_reset++;
        if (ow_read && eb == 6'd63) rd8_active = 1;
        ow_busy = 1;
        len = (long_cmd2 && cmd2_busy) ? 20 : int'($urandom_range(1, 4));
        for (int i = 0; i < len; i++) begin
          @(posedge clk); #1;
          if (ow_reset || ow_write || ow_read) begin
            bad++; total++;
            $display("FAIL cmd_while_busy: cmd=%b seen while busy, required 000", {ow_reset, ow_write, ow_read});
          end
          if (!skip_hold && (ow_in_byte !== ib || ow_start_bit !== sb || ow_end_bit !== eb)) begin
            bad++; total++;
            $display("FAIL hold: in=%h sb=%0d eb=%0d, required in=%h sb=%0d eb=%0d",
                     ow_in_byte, ow_start_bit, ow_end_bit, ib, sb, eb);
          end
        end
        if (cmd == 3'b100) ow_presence = dev_present;
        if (cmd == 3'b001) begin
          if (eb == 6'd0) begin
            n_poll++;
            ow_out_byte = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFE;
            ow_out_byte[0] = (dev_done_poll != 0) && (n_poll >= dev_done_poll);
          end else if (eb == 6'd63) begin
            n_rd8++;
            for (int i = 0; i < 8; i++) ow_out_byte[8*i +: 8] = dev_sp[i];
          end else begin
            n_rdc++;
            ow_out_byte = {$urandom, $urandom};
            ow_out_byte[7:0] = dev_sp[8];
          end
        end
        rd8_active = 0;
        cmd2_busy = 0;
        ow_busy = hold_busy;
      end
    end
  end

  task automatic clear_counts();
    n_reset = 0; n_write = 0; n_poll = 0; n_rd8 = 0; n_rdc = 0; n_cmd = 0;
    n_valid = 0; n_nodev = 0; n_crc = 0; n_tmo = 0;
  endtask

  task automatic set_good_sp();
    logic [7:0] v [9] = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
    dev_sp = v;
  endtask

  task automatic run_txn(input string tag, input bit poke_rd8);
    int kind, cyc, want_reset, want_write;
    bit poked;
    logic [15:0] want_temp;
    if (!dev_present) kind = K_NODEV;
    else if (dev_done_poll == 0) kind = K_TMO;
    else if (crc_model() == dev_sp[8]) kind = K_VALID;
    else kind = K_CRC;
    want_temp  = (kind == K_VALID) ? {dev_sp[1], dev_sp[0]} : exp_temp;
    want_reset = (kind == K_VALID || kind == K_CRC) ? 2 : 1;
    want_write = (kind == K_NODEV) ? 0 : (kind == K_TMO) ? 1 : 2;
    clear_counts();
    cyc = 0;
    while (!ready && cyc < 200) begin tick(); cyc++; end
    start = 1; tick(); start = 0;
    cyc = 0; poked = 0;
    while ((n_valid + n_nodev + n_crc + n_tmo) == 0 && cyc < 6000) begin
      tick(); cyc++;
      if (start) start = 0;
      else if (poke_rd8 && rd8_active && !poked) begin start = 1; poked = 1; end
    end
    start = 0;
    total++;
    if (cyc >= 6000) begin bad++; $display("FAIL %s done_wait: no result in %0d cycles", tag, cyc); end
    repeat (12) tick();
    total++;
    if (n_valid != (kind == K_VALID) || n_crc != (kind == K_CRC) ||
        n_nodev != (kind == K_NODEV) || n_tmo != (kind == K_TMO)) begin
      bad++;
      $display("FAIL %s pulses: valid=%0d crc=%0d nodev=%0d tmo=%0d, required kind %0d once",
               tag, n_valid, n_crc, n_nodev, n_tmo, kind);
    end
    total++;
    if (temp !== want_temp) begin bad++; $display("FAIL %s temp: got %h want %h", tag, temp, want_temp); end
    total++;
    if (n_reset != want_reset || n_write != want_write) begin
      bad++;
      $display("FAIL %s cmd_count: resets=%0d writes=%0d, required %0d %0d", tag, n_reset, n_write, want_reset, want_write);
    end
    if (want_write >= 1) begin
      total++;
      if (w_data[0] !== 16'h44CC || w_eb[0] !== 6'd15) begin
        bad++; $display("FAIL %s write1: got %h end=%0d want 44cc end=15", tag, w_data[0], w_eb[0]);
      end
    end
    if (want_write == 2) begin
      total++;
      if (w_data[1] !== 16'hBECC || w_eb[1] !== 6'd15) begin
        bad++; $display("FAIL %s write2: got %h end=%0d want becc end=15", tag, w_data[1], w_eb[1]);
      end
      total++;
      if (n_poll != dev_done_poll || n_rd8 != 1 || n_rdc != 1) begin
        bad++;
        $display("FAIL %s reads: polls=%0d rd8=%0d rdc=%0d, required %0d 1 1", tag, n_poll, n_rd8, n_rdc, dev_done_poll);
      end
    end
    if (kind == K_TMO) begin
      total++;
      if (n_poll < 1 || n_rd8 != 0) begin
        bad++; $display("FAIL %s tmo_reads: polls=%0d rd8=%0d, required >=1 and 0", tag, n_poll, n_rd8);
      end
    end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL %s ready_after: got %0b want 1", tag, ready); end
    exp_temp = want_temp;
    $display("txn %s kind=%0d polls=%0d temp=%h", tag, kind, n_poll, temp);
  endtask

  task automatic test_reset();
    reset = 1; start = 0;
    repeat (3) tick();
    reset = 0; tick();
    total++;
    if ({ow_reset, ow_write, ow_read, temp_valid, err_nodev, err_crc, err_timeout} !== 7'd0) begin
      bad++; $display("FAIL reset_pulses: got %b want 0000000",
                      {ow_reset, ow_write, ow_read, temp_valid, err_nodev, err_crc, err_timeout});
    end
    total++;
    if (temp !== 16'h0 || ow_in_byte !== 64'h0 || ow_start_bit !== 6'd0 || ow_end_bit !== 6'd0) begin
      bad++; $display("FAIL reset_regs: temp=%h in=%h sb=%0d eb=%0d want zeros", temp, ow_in_byte, ow_start_bit, ow_end_bit);
    end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", ready); end
    $display("txn reset ready=%0b temp=%h", ready, temp);
  endtask

  task automatic test_good_read();
    set_good_sp(); dev_present = 1; dev_done_poll = 4;
    run_txn("good_read", 0);
  endtask

  task automatic test_bad_crc();
    set_good_sp(); dev_sp[8] = 8'h1D; dev_present = 1; dev_done_poll = 4;
    run_txn("bad_crc", 0);
  endtask

  task automatic test_no_device();
    set_good_sp(); dev_present = 0; dev_done_poll = 4;
    run_txn("no_device", 0);
    dev_present = 1;
  endtask

  task automatic test_timeout();
    set_good_sp(); dev_present = 1; dev_done_poll = 0;
    run_txn("timeout", 0);
  endtask

  task automatic test_ignored_starts();
    clear_counts();
    hold_busy = 1;
    repeat (3) tick();
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL busy_ready: got %0b want 0", ready); end
    start = 1; tick(); start = 0;
    repeat (5) tick();
    hold_busy = 0;
    repeat (20) tick();
    total++;
    if (n_cmd != 0 || (n_valid + n_nodev + n_crc + n_tmo) != 0) begin
      bad++; $display("FAIL busy_start: cmds=%0d pulses=%0d want 0 0", n_cmd, n_valid + n_nodev + n_crc + n_tmo);
    end
    set_good_sp(); dev_present = 1; dev_done_poll = 2;
    run_txn("start_in_rd8", 1);
    repeat (20) tick();
    total++;
    if (n_reset != 2 || (n_valid + n_nodev + n_crc + n_tmo) != 1) begin
      bad++; $display("FAIL rd8_start: resets=%0d pulses=%0d want 2 1", n_reset, n_valid + n_nodev + n_crc + n_tmo);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    set_good_sp(); dev_present = 1; dev_done_poll = 1;
    clear_counts();
    long_cmd2 = 1;
    cyc = 0;
    while (!ready && cyc < 200) begin tick(); cyc++; end
    start = 1; tick(); start = 0;
    cyc = 0;
    while (!cmd2_busy && cyc < 3000) begin tick(); cyc++; end
    total++;
    if (!cmd2_busy) begin bad++; $display("FAIL mid_reach_cmd2: not reached in %0d cycles", cyc); end
    skip_hold = 1;
    reset = 1; tick(); reset = 0;
    total++;
    if ({ow_reset, ow_write, ow_read} !== 3'b000 || ready !== 1'b0 || ow_busy !== 1'b1) begin
      bad++; $display("FAIL mid_reset: cmds=%b ready=%0b busy=%0b want 000 0 1",
                      {ow_reset, ow_write, ow_read}, ready, ow_busy);
    end
    cyc = 0;
    while (ow_busy && cyc < 100) begin
      tick(); cyc++;
      if (ow_busy && ready) begin
        bad++; total++; $display("FAIL mid_ready_early: ready=1 while busy");
      end
    end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after: got %0b want 1", ready); end
    total++;
    if ((n_valid + n_nodev + n_crc + n_tmo) != 0) begin
      bad++; $display("FAIL mid_pulses: got %0d want 0", n_valid + n_nodev + n_crc + n_tmo);
    end
    long_cmd2 = 0; skip_hold = 0;
    dev_done_poll = 3;
    run_txn("after_reset", 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      dev_present = ($urandom_range(0, 5) != 0);
      dev_done_poll = $urandom_range(0, 4);
      for (int i = 0; i < 8; i++) dev_sp[i] = 8'($urandom);
      dev_sp[8] = crc_model();
      if ($urandom_range(0, 1) == 1) dev_sp[8] = dev_sp[8] ^ 8'($urandom_range(1, 255));
      run_txn($sformatf("random%0d", t), 0);
    end
    dev_present = 1;
  endtask

  initial begin
    reset = 1; start = 0;
    test_reset();
    test_good_read();
    test_bad_crc();
    test_no_device();
    test_timeout();
    test_ignored_starts();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ds18b20_ctrl.md
Name: ds18b20_ctrl

Overview:
- Transaction sequencer directly upstream of the 1-Wire bit engine (one_wire).
- On a start pulse it runs one complete DS18B20 temperature read: reset/presence, Skip ROM + Convert T, poll for conversion done, reset, Skip ROM + Read Scratchpad, read 9 bytes, CRC-8 check.
- Reports the 16-bit raw temperature, or an error flag, to the host logic (SPI register file).

Parameters:
- CONV_TIMEOUT, 18000000, clocks allowed for conversion polling (750 ms at 24 MHz).
- POLL_GAP, 24000, idle clocks between conversion poll slots (1 ms).

Ports:
- clk  in  1  24 MHz clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; ignored unless ready=1
- ready  out  1  idle and engine not busy
- temp  out  16  scratchpad bytes 1:0, {byte1,byte0}
- temp_valid  out  1  one-cycle pulse, temp updated
- err_nodev  out  1  one-cycle pulse, no presence pulse
- err_crc  out  1  one-cycle pulse, CRC mismatch
- err_timeout  out  1  one-cycle pulse, conversion not done within CONV_TIMEOUT
- ow_reset  out  1  engine reset/presence command
- ow_write  out  1  engine write command
- ow_read  out  1  engine read command
- ow_in_byte  out  64  write data, LSB first
- ow_start_bit  out  6  first bit index
- ow_end_bit  out  6  last bit index
- ow_busy  in  1  engine busy
- ow_presence  in  1  engine presence result
- ow_out_byte  in  64  engine read data

Behaviour:
- Reset values: all command and pulse outputs 0; temp 0; ow_in_byte 0; start/end bits 0; state IDLE. ready = (state==IDLE && !ow_busy).
- Engine handshake, per engine operation, in three phases:
  - ISSUE: assert exactly one command for one cycle, with in_byte/start/end valid.
  - WAIT_BUSY: wait for ow_busy=1.
  - WAIT_IDLE: wait for ow_busy=0.
  - ow_in_byte, start_bit and end_bit are held unchanged from ISSUE until WAIT_IDLE exits.
- Never issue a command while ow_busy=1.
- States:
  - IDLE: start && ready -> RST1.
  - RST1: ow_reset. On completion: ow_presence=0 -> err_nodev, IDLE; else CMD1.
  - CMD1: ow_write, in_byte[15:0]=16'h44CC, bits 0..15 -> CONV.
  - CONV: ow_read, bits 0..0. out_byte[0]=1 -> RST2. Else wait POLL_GAP, then re-poll.
    - Conversion timer starts on CONV entry. When timer reaches CONV_TIMEOUT at a poll decision -> err_timeout, IDLE.
  - RST2: same as RST1; success -> CMD2.
  - CMD2: ow_write, in_byte[15:0]=16'hBECC, bits 0..15 -> RD8.
  - RD8: ow_read, bits 0..63; latch out_byte into 64-bit scratchpad register -> RDC.
  - RDC: ow_read, bits 0..7; latch out_byte[7:0] as crc_rx -> CRC.
  - CRC: 64 cycles, one scratchpad bit per clock, LSB first, into the CRC unit; then compare with crc_rx.
    - Equal: temp <= sp[15:0], temp_valid pulse.
    - Not equal: err_crc pulse; temp unchanged.
    - Either case -> IDLE.
- Exactly one of temp_valid/err_* pulses per accepted start.
- CRC: Dallas CRC-8, x^8+x^5+x^4+1, reflected form 0x8C, init 0x00, cleared on CRC entry.
- start while not ready is dropped, not queued.
- Reset mid-operation: immediate return to IDLE, commands deasserted, no result pulse. The engine may still be finishing a slot; ready stays 0 until ow_busy=0.
- Counters: conversion timer 25 bits, saturating; gap counter 15 bits.

Decomposition:
- Package ds18b20_pkg holds:
  - ROM/function command constants: SKIP_ROM 8'hCC, CONVERT_T 8'h44, READ_SCRATCH 8'hBE.
  - State enum.
  - CRC polynomial 8'h8C.
- Sub-module ds_crc8: bit-serial CRC-8 with clr, en, din, crc[7:0].

Test Plan:
- Device model returns power-on scratchpad 50 05 4B 46 7F FF 0C 10 1C; busy on 3rd poll -> temp=16'h0550, one temp_valid pulse, no errors, exactly 4 engine writes/reads in CONV.
- Same but byte 8 = 1D -> err_crc pulse; temp retains previous value.
- No device (presence=0) -> err_nodev after RST1, no ow_write ever issued, ready returns to 1.
- Conversion never completes, CONV_TIMEOUT=2000, POLL_GAP=100 -> err_timeout pulse; no RST2 issued.
- start pulsed during RD8 and again while ow_busy=1 in IDLE -> both ignored; only one result pulse total.
- reset asserted in CMD2 while engine busy -> commands go 0 next cycle, ready=0 until ow_busy falls, then a new start completes normally with temp=16'h0550.
